// File: rtl/data_io_pkg.sv
// Shared constants and types for the IO-controller file download port.
// Command codes match the ARM IO controller's user_io protocol.
package data_io_pkg;

  localparam logic [7:0] UIO_FILE_TX     = 8'h53;
  localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
  localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } dl_state_t;

  function automatic int lane_count(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/data_io_wide_spi_byte_rx.sv
// Oversampling SPI byte receiver: synchronises sck/ss/sdi into clk and
// emits one-cycle strobes for the command byte and each payload byte.
module spi_byte_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       ss,
  input  logic       sdi,
  output logic [7:0] cmd,
  output logic [7:0] data,
  output logic       cmd_stb,
  output logic       byte_stb
);

  logic       sck_meta, sck_sync, sck_prev;
  logic       ss_meta, ss_sync;
  logic       sdi_meta, sdi_sync;
  logic       armed;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic       sck_rise;

  assign sck_rise = sck_sync & ~sck_prev & ~ss_sync;

  // The receiver stays disarmed after reset until a deselect is observed,
  // so a frame interrupted by reset cannot be misaligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_meta <= 1'b0;
      sck_sync <= 1'b0;
      sck_prev <= 1'b0;
      ss_meta  <= 1'b0;
      ss_sync  <= 1'b0;
      sdi_meta <= 1'b0;
      sdi_sync <= 1'b0;
      armed    <= 1'b0;
      bit_cnt  <= 4'd0;
      shift    <= 8'h00;
      cmd_stb  <= 1'b0;
      byte_stb <= 1'b0;
    end else begin
      sck_meta <= sck;
      sck_sync <= sck_meta;
      sck_prev <= sck_sync;
      ss_meta  <= ss;
      ss_sync  <= ss_meta;
      sdi_meta <= sdi;
      sdi_sync <= sdi_meta;
      cmd_stb  <= 1'b0;
      byte_stb <= 1'b0;
      if (ss_sync) begin
        armed   <= 1'b1;
        bit_cnt <= 4'd0;
      end else if (sck_rise && armed) begin
        shift <= {shift[6:0], sdi_sync};
        if (bit_cnt == 4'd7) begin
          cmd_stb <= 1'b1;
          bit_cnt <= 4'd8;
        end else if (bit_cnt == 4'd15) begin
          byte_stb <= 1'b1;
          bit_cnt  <= 4'd8;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

  assign cmd  = shift;
  assign data = shift;

endmodule

// File: rtl/data_io_wide.sv
// IO-controller download port: decodes file transfer commands, packs bytes
// into DW-bit words and hands them to RAM through a wr/wr_ack handshake.
module data_io_wide #(
  parameter int            DW         = 8,
  parameter int            AW         = 25,
  parameter logic [AW-1:0] START_ADDR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sck,
  input  logic            ss,
  input  logic            sdi,
  output logic            downloading,
  output logic [AW-1:0]   size,
  output logic [7:0]      index,
  output logic            wr,
  input  logic            wr_ack,
  output logic [AW-1:0]   a,
  output logic [DW-1:0]   d,
  output logic [DW/8-1:0] be,
  output logic            overflow
);
  import data_io_pkg::*;

  localparam int            LANES     = lane_count(DW);
  localparam int            LW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  dl_state_t        state, state_next;
  logic [7:0]       rx_cmd, rx_data, cur_cmd;
  logic             cmd_stb, byte_stb;
  logic [AW-1:0]    next_addr;
  logic [LW-1:0]    lane_ptr;
  logic [DW-1:0]    word_buf, buf_merged, word_d;
  logic [LANES-1:0] word_be, be_merged, word_be_out;
  logic             start_stb, end_stb, data_stb;
  logic             fill_done, flush_done, word_done;
  logic             accept, drop, pending_next;

  spi_byte_rx u_rx (
    .clk      (clk),
    .reset    (reset),
    .sck      (sck),
    .ss       (ss),
    .sdi      (sdi),
    .cmd      (rx_cmd),
    .data     (rx_data),
    .cmd_stb  (cmd_stb),
    .byte_stb (byte_stb)
  );

  // Byte decode, lane merge and word-issue decisions for this cycle.
  always_comb begin
    start_stb  = byte_stb && (cur_cmd == UIO_FILE_TX) && rx_data[0];
    end_stb    = byte_stb && (cur_cmd == UIO_FILE_TX) && !rx_data[0] && (state == ST_LOAD);
    data_stb   = byte_stb && (cur_cmd == UIO_FILE_TX_DAT) && (state == ST_LOAD);
    buf_merged = word_buf;
    be_merged  = word_be;
    for (int i = 0; i < LANES; i++) begin
      if (lane_ptr == LW'(i)) begin
        buf_merged[8*i +: 8] = rx_data;
        be_merged[i]         = 1'b1;
      end else begin
        buf_merged[8*i +: 8] = word_buf[8*i +: 8];
        be_merged[i]         = word_be[i];
      end
    end
    fill_done  = data_stb && (lane_ptr == LAST_LANE);
    flush_done = end_stb && (lane_ptr != '0);
    word_done  = fill_done || flush_done;
    if (fill_done) begin
      word_d      = buf_merged;
      word_be_out = '1;
    end else begin
      word_d      = word_buf;
      word_be_out = word_be;
    end
    accept       = word_done && (!wr || wr_ack);
    drop         = word_done && wr && !wr_ack;
    pending_next = accept || (wr && !wr_ack);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_stb) state_next = ST_LOAD;
        else           state_next = ST_IDLE;
      end
      ST_LOAD: begin
        if (start_stb)    state_next = ST_LOAD;
        else if (end_stb) state_next = pending_next ? ST_FLUSH : ST_IDLE;
        else              state_next = ST_LOAD;
      end
      ST_FLUSH: begin
        if (start_stb)            state_next = ST_LOAD;
        else if (!wr || wr_ack)   state_next = ST_IDLE;
        else                      state_next = ST_FLUSH;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A start aborts any pending write; otherwise completed words either load
  // the output register or are dropped when the previous one is unacknowledged.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_cmd     <= 8'h00;
      index       <= 8'h00;
      downloading <= 1'b0;
      next_addr   <= '0;
      size        <= '0;
      lane_ptr    <= '0;
      word_buf    <= '0;
      word_be     <= '0;
      overflow    <= 1'b0;
      wr          <= 1'b0;
      a           <= '0;
      d           <= '0;
      be          <= '0;
    end else begin
      if (cmd_stb) cur_cmd <= rx_cmd;
      if (byte_stb && (cur_cmd == UIO_FILE_INDEX)) index <= rx_data;
      downloading <= (state_next != ST_IDLE);
      if (start_stb) begin
        next_addr <= START_ADDR;
        size      <= '0;
        lane_ptr  <= '0;
        word_buf  <= '0;
        word_be   <= '0;
        overflow  <= 1'b0;
        wr        <= 1'b0;
      end else begin
        if (data_stb) begin
          size <= size + AW'(1);
          if (fill_done) begin
            lane_ptr  <= '0;
            word_buf  <= '0;
            word_be   <= '0;
            next_addr <= next_addr + AW'(LANES);
          end else begin
            lane_ptr <= lane_ptr + LW'(1);
            word_buf <= buf_merged;
            word_be  <= be_merged;
          end
        end else if (flush_done) begin
          lane_ptr  <= '0;
          word_buf  <= '0;
          word_be   <= '0;
          next_addr <= next_addr + AW'(LANES);
        end
        if (accept) begin
          wr <= 1'b1;
          a  <= next_addr;
          d  <= word_d;
          be <= word_be_out;
        end else if (wr && wr_ack) begin
          wr <= 1'b0;
        end
        if (drop) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_io_wide.sv
// Directed bench: a DW=8 (START_ADDR=0x1000) and a DW=16 instance share one
// SPI stream; each has its own wr_ack driver and write log.
module tb_data_io_wide;

  logic        clk, reset, sck, ss, sdi;
  logic        ack8, ack16;
  logic        dl8, dl16, wr8, wr16, ovf8, ovf16;
  logic [24:0] size8, size16, a8, a16;
  logic [7:0]  index8, index16, d8;
  logic [15:0] d16;
  logic [0:0]  be8;
  logic [1:0]  be16;

  int total = 0;
  int passed = 0;
  int failed = 0;
  bit auto16 = 1'b1;
  bit seen8 = 1'b0;
  bit seen16 = 1'b0;
  logic [33:0] q8[$];
  logic [42:0] q16[$];
  logic [33:0] v8;
  logic [42:0] v16;
  logic [7:0]  pat;

  data_io_wide #(.DW(8), .AW(25), .START_ADDR(25'h1000)) dut8 (
    .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi),
    .downloading(dl8), .size(size8), .index(index8), .wr(wr8), .wr_ack(ack8),
    .a(a8), .d(d8), .be(be8), .overflow(ovf8));

  data_io_wide #(.DW(16), .AW(25), .START_ADDR(25'h0)) dut16 (
    .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi),
    .downloading(dl16), .size(size16), .index(index16), .wr(wr16), .wr_ack(ack16),
    .a(a16), .d(d16), .be(be16), .overflow(ovf16));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Auto-acknowledge one cycle after wr is seen, logging each accepted word.
  initial begin
    ack8 = 1'b0;
    forever begin
      @(negedge clk);
      if (wr8 && seen8 && !ack8) begin
        q8.push_back({a8, d8, be8});
        ack8 = 1'b1;
      end else begin
        ack8 = 1'b0;
      end
      seen8 = wr8;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (auto16) begin
        if (wr16 && seen16 && !ack16) begin
          q16.push_back({a16, d16, be16});
          ack16 = 1'b1;
        end else begin
          ack16 = 1'b0;
        end
      end
      seen16 = wr16;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // force_ack raises ack16 exactly in the cycle the receiver strobes this bit's byte.
  task automatic send_bit(input logic b, input logic force_ack);
    @(negedge clk); sdi = b; sck = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk); sck = 1'b1;
    if (force_ack) begin
      repeat (3) @(posedge clk);
      @(negedge clk); ack16 = 1'b1;
      @(negedge clk); ack16 = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input logic force_last);
    for (int i = 7; i >= 0; i--) send_bit(v[i], force_last && (i == 0));
  endtask

  task automatic begin_frame();
    @(negedge clk); ss = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk); sck = 1'b0;
    repeat (4) @(negedge clk);
    ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame2(input logic [7:0] c, input logic [7:0] p);
    begin_frame();
    send_byte(c, 1'b0);
    send_byte(p, 1'b0);
    end_frame();
  endtask

  initial begin
    reset = 1'b1; ss = 1'b1; sck = 1'b0; sdi = 1'b0; ack16 = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_dl8", dl8, 0);       check("rst_size8", size8, 0);
    check("rst_index8", index8, 0); check("rst_wr8", wr8, 0);
    check("rst_a8", a8, 0);         check("rst_d8", d8, 0);
    check("rst_be8", be8, 0);       check("rst_ovf8", ovf8, 0);
    check("rst_wr16", wr16, 0);     check("rst_dl16", dl16, 0);

    // DW=8 basic download, DW=16 packs the same two bytes
    frame2(8'h53, 8'h01);
    check("t1_dl8_up", dl8, 1); check("t1_size8_0", size8, 0); check("t1_dl16_up", dl16, 1);
    q8.delete(); q16.delete();
    begin_frame();
    send_byte(8'h54, 1'b0); send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
    end_frame();
    check("t1_size8", size8, 2); check("t1_wr8_idle", wr8, 0);
    frame2(8'h53, 8'h00);
    check("t1_dl8_down", dl8, 0); check("t1_q8_n", q8.size(), 2);
    v8 = (q8.size() > 0) ? q8[0] : 'x;
    check("t1_w8_0", v8, {25'h1000, 8'hAA, 1'b1});
    v8 = (q8.size() > 1) ? q8[1] : 'x;
    check("t1_w8_1", v8, {25'h1001, 8'hBB, 1'b1});
    check("t1_q16_n", q16.size(), 1);
    v16 = (q16.size() > 0) ? q16[0] : 'x;
    check("t1_w16_0", v16, {25'h0, 16'hBBAA, 2'b11});
    check("t1_dl16_down", dl16, 0);

    // DW=16 odd length with final partial word
    frame2(8'h53, 8'h01);
    q16.delete();
    begin_frame();
    send_byte(8'h54, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
    end_frame();
    check("t2_size16", size16, 3);
    @(negedge clk); auto16 = 1'b0; ack16 = 1'b0;
    frame2(8'h53, 8'h00);
    check("t2_q16_n", q16.size(), 1);
    v16 = (q16.size() > 0) ? q16[0] : 'x;
    check("t2_w16_0", v16, {25'h0, 16'h2211, 2'b11});
    check("t2_wr16", wr16, 1); check("t2_a16", a16, 25'h2);
    check("t2_d16", d16, 16'h0033); check("t2_be16", be16, 2'b01);
    check("t2_dl16_hold", dl16, 1);
    @(negedge clk); ack16 = 1'b1;
    @(negedge clk); ack16 = 1'b0;
    check("t2_wr16_drop", wr16, 0); check("t2_dl16_fall", dl16, 0);

    // overflow with wr_ack held low; a new start aborts and clears
    frame2(8'h53, 8'h01);
    check("t3_ovf16_0", ovf16, 0);
    begin_frame();
    send_byte(8'h54, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
    end_frame();
    check("t3_wr16", wr16, 1); check("t3_a16", a16, 25'h0);
    check("t3_d16", d16, 16'h0201); check("t3_be16", be16, 2'b11);
    check("t3_ovf16", ovf16, 1); check("t3_size16", size16, 4);
    frame2(8'h53, 8'h01);
    check("t3_abort_wr", wr16, 0); check("t3_ovf_clr", ovf16, 0); check("t3_size_clr", size16, 0);

    // word completes in the same cycle as wr_ack
    begin_frame();
    send_byte(8'h54, 1'b0); send_byte(8'hA1, 1'b0); send_byte(8'hB2, 1'b0); send_byte(8'hC3, 1'b0);
    check("t4_wr16_pend", wr16, 1); check("t4_a16_pend", a16, 25'h0); check("t4_d16_pend", d16, 16'hB2A1);
    send_byte(8'hD4, 1'b1);
    end_frame();
    check("t4_wr16_held", wr16, 1); check("t4_a16_next", a16, 25'h2);
    check("t4_d16_next", d16, 16'hD4C3); check("t4_ovf16", ovf16, 0); check("t4_size16", size16, 4);
    q16.delete(); auto16 = 1'b1;
    repeat (8) @(negedge clk);
    check("t4_wr16_done", wr16, 0); check("t4_q16_n", q16.size(), 1);
    v16 = (q16.size() > 0) ? q16[0] : 'x;
    check("t4_w16", v16, {25'h2, 16'hD4C3, 2'b11});
    frame2(8'h53, 8'h00);
    check("t4_dl16_fall", dl16, 0);

    // index command, then data with no start
    frame2(8'h55, 8'h07);
    check("t5_index8", index8, 8'h07); check("t5_index16", index16, 8'h07);
    q8.delete(); q16.delete();
    begin_frame();
    send_byte(8'h54, 1'b0); send_byte(8'h99, 1'b0); send_byte(8'h88, 1'b0);
    end_frame();
    check("t5_wr8", wr8, 0); check("t5_wr16", wr16, 0);
    check("t5_q8_n", q8.size(), 0); check("t5_q16_n", q16.size(), 0);
    check("t5_size16", size16, 4); check("t5_ovf8", ovf8, 0);

    // reset in the middle of a payload byte with ss still low
    pat = 8'h3C;
    begin_frame();
    send_byte(8'h55, 1'b0);
    for (int i = 7; i >= 4; i--) send_bit(pat[i], 1'b0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 3; i >= 0; i--) send_bit(pat[i], 1'b0);
    send_byte(8'h66, 1'b0);
    end_frame();
    check("t6_index16", index16, 8'h00); check("t6_index8", index8, 8'h00);
    check("t6_wr16", wr16, 0); check("t6_dl16", dl16, 0); check("t6_size16", size16, 0);
    check("t6_q8_n", q8.size(), 0); check("t6_q16_n", q16.size(), 0);
    frame2(8'h55, 8'h2A);
    check("t6_index16_new", index16, 8'h2A); check("t6_index8_new", index8, 8'h2A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/data_io_wide.md
Name: data_io_wide

Overview:
Parametrised next-generation IO-controller download port. Receives the ARM IO controller's SPI byte stream (commands 0x53/0x54/0x55) by oversampling sck/ss/sdi in the core clock domain. Packs file bytes into DW-bit words and writes them to external RAM through a wr/wr_ack handshake with byte enables, final-word flush and overflow detection. Sits between the user_io SPI bus and the core's SDRAM/BRAM loader mux.

Parameters:
DW, 8, RAM data width in bits; legal values 8 or 16.
AW, 25, byte-address and size width.
START_ADDR, 0, byte address of the first downloaded byte; must be DW/8-aligned.

Ports:
clk  in  1  core clock; must be at least 4x sck frequency.
reset  in  1  synchronous, active-high reset.
sck  in  1  SPI clock from IO controller (asynchronous).
ss  in  1  SPI select, active high = idle (asynchronous).
sdi  in  1  SPI data, MSB first, sampled on sck rising edge (asynchronous).
downloading  out  1  high from download start until the final word is acknowledged.
size  out  AW  bytes received in the current/last download.
index  out  8  menu index from the last 0x55 command.
wr  out  1  write request; held until acknowledged.
wr_ack  in  1  RAM accepted the word presented this cycle.
a  out  AW  byte address of the word's lowest byte.
d  out  DW  write data; byte 0 in d[7:0], little-endian.
be  out  DW/8  byte enables; bit i covers d[8i+7:8i].
overflow  out  1  sticky: a completed word was dropped because wr was still pending.

Behaviour:
- Reset values: downloading=0, size=0, index=0, wr=0, a=0, d=0, be=0, overflow=0; bit counter=0; disarmed.
- Inputs pass through a 2-flop synchroniser. An sck edge is the cycle in which synced sck goes 0->1 while synced ss=0.
- Synced ss=1 sets bit counter to 0 and arms the receiver. After reset the receiver is disarmed and ignores all sck edges until ss is seen high.
- Bit counter sequence: 0..7 for the command byte, then 8..15 repeating for each payload byte. Command is latched when bit 7 is sampled. A payload byte completes when bit 15 is sampled (cycle N).
- Cmd 0x53, payload bit0=1 (start):
  - next byte address = START_ADDR; size=0; lane pointer=0; overflow=0; downloading=1 in N+1.
  - Start while a write is pending aborts it: wr=0.
- Cmd 0x53, payload bit0=0 (end):
  - If a partial word exists (DW=16, odd size), it is issued as a write with unfilled lanes be=0 and data 0.
  - downloading falls in the cycle after the last outstanding wr_ack. If nothing is pending, it falls in N+1.
- Cmd 0x54 (data), per byte:
  - byte stored in lane[pointer]; size increments in N+1.
  - When the last lane fills, the word completes: wr=1 in N+1 with a=word byte address, be=all ones, d=word. The next word address advances by DW/8.
  - Bytes received while downloading=0 are ignored.
- Cmd 0x55: index=payload byte in N+1.
- Handshake:
  - a/d/be stable while wr=1. wr drops the cycle after the wr_ack cycle.
  - wr_ack while wr=0 is ignored.
  - Word completes while wr=1 and wr_ack=0: the new word is dropped, overflow=1, size still counts. A conforming controller has at most one outstanding write.
  - Word completes in the same cycle as wr_ack: the new word is presented next cycle and wr stays high.
- Address arithmetic is modulo 2^AW. size wraps silently at 2^AW.
- Unknown commands: payload ignored; counter still cycles 8..15.
- Reset mid-transfer: all state cleared. Remaining bits of the current ss-low frame are ignored (disarmed).

Decomposition:
- Package data_io_pkg: UIO_FILE_TX=8'h53, UIO_FILE_TX_DAT=8'h54, UIO_FILE_INDEX=8'h55; function computing lane count DW/8.
- Sub-module spi_byte_rx:
  - performs synchroniser, edge detect, arm logic and bit counter;
  - outputs cmd[7:0], byte[7:0], cmd_stb, byte_stb (1-cycle pulses at cycle N).
- Top level holds download FSM (IDLE, LOAD, FLUSH), lane packer and write handshake.

Test Plan:
- DW=8, START_ADDR=0x1000: 0x53/0x01, 0x54 bytes 0xAA 0xBB, 0x53/0x00, wr_ack 1 cycle after wr -> writes (0x1000,0xAA,be=1) and (0x1001,0xBB,be=1); size=2; downloading 1->0.
- DW=16: 3 data bytes 11 22 33 then end -> writes (0x0,d=0x2211,be=2'b11) and (0x2,d=0x0033,be=2'b01). downloading falls only after the second ack.
- DW=16, wr_ack held low across two completed words -> first word stays on a/d, second is dropped, overflow=1. A new start clears overflow.
- 0x55 frame with payload 0x07, ss toggled between frames -> index=7. Data bytes sent with no prior start -> no wr.
- reset pulsed mid-payload byte with ss still low, then the frame continues -> no wr, no index change. Next ss-high-framed command is decoded correctly.
- Word completes in the same cycle as wr_ack (forced by bench) -> wr stays high, a advances by DW/8, overflow stays 0.
